mapping_req_arbiter: RTL and testbench

- Upstream of the hashed-paging mapping IP.
- Merges the separate read and write request AXI-Stream channels into a single lookup-request stream for the mapping core.
- Fair round-robin arbitration between the two channels.
- Bounds the number of in-flight requests with a credit counter that is returned by response-completion pulses from the downstream output stage.
- One registered output slot: one-cycle latency, full throughput of one request per cycle.

---
 rtl/mapping_req_arbiter.sv | 128 ++++++++++++
 tb/tb_mapping_req_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mapping_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mapping_req_arbiter
// Purpose  : Merges the read and write lookup-request AXI-Stream channels
//            into one request stream for the hashed-paging mapping core.
//            Round-robin arbitration between the channels, one registered
//            output slot (1-cycle latency, 1 req/cycle), and a credit counter
//            that bounds in-flight requests. Credits come back as rsp_done
//            pulses from the downstream output stage.
// Ports    : ap_clk, ap_rst_n        - clock, async active-low reset
//            in_read_*  (tdata/tvalid/tready)  - read request stream
//            in_write_* (tdata/tvalid/tready)  - write request stream
//            out_tdata/tvalid/tready, out_is_write - merged request stream
//            rsp_done                - one pulse per completed request
//            outstanding             - current in-flight count
//            err_underflow           - sticky: rsp_done seen with count 0
// Revision : 1.0 - initial release
// ============================================================================
module mapping_req_arbiter #(
  parameter int DATA_WIDTH      = 73,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] in_read_tdata,
  input  logic                  in_read_tvalid,
  output logic                  in_read_tready,
  input  logic [DATA_WIDTH-1:0] in_write_tdata,
  input  logic                  in_write_tvalid,
  output logic                  in_write_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_is_write,
  input  logic                  rsp_done,
  output logic [CNT_WIDTH-1:0]  outstanding,
  output logic                  err_underflow
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  grant_e last_grant;

  logic slot_free;
  logic credit_ok;
  logic grant_read;
  logic grant_write;
  logic grant_any;
  logic cnt_dec;

  // The slot can take a new request when it is empty or being drained now.
  assign slot_free = !out_tvalid || out_tready;
  // Credit uses the registered count only: an rsp_done in the same cycle
  // frees the credit for the following cycle, not this one.
  assign credit_ok = (outstanding < MAX_CNT);

  // Grant selection. ap_rst_n gates the grant so both treadys stay low for
  // the whole time reset is asserted, not just at clock edges.
  always_comb begin
    grant_read  = 1'b0;
    grant_write = 1'b0;
    if (ap_rst_n && slot_free && credit_ok) begin
      if (in_read_tvalid && in_write_tvalid) begin
        // Tie: serve the channel that did not win last time.
        if (last_grant == GRANT_WRITE) begin
          grant_read = 1'b1;
        end else begin
          grant_write = 1'b1;
        end
      end else if (in_read_tvalid) begin
        grant_read = 1'b1;
      end else if (in_write_tvalid) begin
        grant_write = 1'b1;
      end
    end
  end

  assign grant_any       = grant_read | grant_write;
  assign in_read_tready  = grant_read;
  assign in_write_tready = grant_write;

  // Output slot and arbitration history.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_tvalid   <= 1'b0;
      out_tdata    <= '0;
      out_is_write <= 1'b0;
      last_grant   <= GRANT_WRITE;
    end else begin
      if (grant_any) begin
        out_tdata    <= grant_write ? in_write_tdata : in_read_tdata;
        out_is_write <= grant_write;
        out_tvalid   <= 1'b1;
        last_grant   <= grant_write ? GRANT_WRITE : GRANT_READ;
      end else if (out_tvalid && out_tready) begin
        out_tvalid <= 1'b0;
      end
    end
  end

  // A completion with nothing outstanding is ignored by the counter and
  // flagged instead.
  assign cnt_dec = rsp_done && (outstanding != '0);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (grant_any && !cnt_dec) begin
        outstanding <= outstanding + CNT_WIDTH'(1);
      end else if (cnt_dec && !grant_any) begin
        outstanding <= outstanding - CNT_WIDTH'(1);
      end
      if (rsp_done && (outstanding == '0)) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mapping_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mapping_req_arbiter
// Purpose  : Self-checking bench for mapping_req_arbiter. A MAX=8 instance
//            runs a table of directed vectors plus hand-written sequences;
//            a MAX=2 instance exercises credit exhaustion and return.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mapping_req_arbiter;

  localparam int DW = 73;

  logic          clk;
  logic          rst_n;

  // MAX_OUTSTANDING = 8 instance
  logic [DW-1:0] rd, wd, otd;
  logic          rv, wv, rr, wr, otv, otr, oiw, rsp, err;
  logic [7:0]    outs;

  // MAX_OUTSTANDING = 2 instance
  logic [DW-1:0] rd2, wd2, otd2;
  logic          rv2, wv2, rr2, wr2, otv2, otr2, oiw2, rsp2, err2;
  logic [7:0]    outs2;

  int n_cmp = 0;
  int n_bad = 0;

  mapping_req_arbiter #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(8), .CNT_WIDTH(8)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_read_tdata(rd), .in_read_tvalid(rv), .in_read_tready(rr),
    .in_write_tdata(wd), .in_write_tvalid(wv), .in_write_tready(wr),
    .out_tdata(otd), .out_tvalid(otv), .out_tready(otr), .out_is_write(oiw),
    .rsp_done(rsp), .outstanding(outs), .err_underflow(err)
  );

  mapping_req_arbiter #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(2), .CNT_WIDTH(8)) dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_read_tdata(rd2), .in_read_tvalid(rv2), .in_read_tready(rr2),
    .in_write_tdata(wd2), .in_write_tvalid(wv2), .in_write_tready(wr2),
    .out_tdata(otd2), .out_tvalid(otv2), .out_tready(otr2), .out_is_write(oiw2),
    .rsp_done(rsp2), .outstanding(outs2), .err_underflow(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    logic [DW-1:0] rd;
    logic          wv;
    logic [DW-1:0] wd;
    logic          otr;
    logic          rsp;
    logic          e_rr;
    logic          e_wr;
    logic          e_tv;
    logic [DW-1:0] e_td;
    logic          e_iw;
    logic [7:0]    e_out;
    logic          e_err;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic a_rv, logic [DW-1:0] a_rd, logic a_wv,
                              logic [DW-1:0] a_wd, logic a_otr, logic a_rsp,
                              logic x_rr, logic x_wr, logic x_tv,
                              logic [DW-1:0] x_td, logic x_iw,
                              logic [7:0] x_out, logic x_err);
    vec_t v;
    v.rv = a_rv; v.rd = a_rd; v.wv = a_wv; v.wd = a_wd; v.otr = a_otr;
    v.rsp = a_rsp; v.e_rr = x_rr; v.e_wr = x_wr; v.e_tv = x_tv;
    v.e_td = x_td; v.e_iw = x_iw; v.e_out = x_out; v.e_err = x_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read payloads in bit 72 = 0, write payloads use bit 72 = 1.
  localparam logic [DW-1:0] A0  = 73'h0_0000_0000_0000_1000;
  localparam logic [DW-1:0] B0  = 73'h1_0000_0000_0000_0B00;
  localparam logic [DW-1:0] A1  = 73'h0_0000_0000_0000_0A01;
  localparam logic [DW-1:0] B1  = 73'h1_0000_0000_0000_0B01;
  localparam logic [DW-1:0] A2  = 73'h0_0000_0000_0000_0A02;
  localparam logic [DW-1:0] B2  = 73'h1_0000_0000_0000_0B02;
  localparam logic [DW-1:0] A3  = 73'h0_0000_0000_0000_0A03;
  localparam logic [DW-1:0] B3  = 73'h1_0000_0000_0000_0B03;
  localparam logic [DW-1:0] A10 = 73'h0_1234_5678_9ABC_DEF0;
  localparam logic [DW-1:0] A11 = 73'h0_0000_0000_0000_0A11;
  localparam logic [DW-1:0] B11 = 73'h1_FFFF_0000_FFFF_0B11;
  localparam logic [DW-1:0] A12 = 73'h0_0000_0000_0000_0A12;
  localparam logic [DW-1:0] B12 = 73'h1_0000_0000_0000_0B12;

  initial begin
    int accepts;

    //                rv rd   wv wd   otr rsp  rr wr tv td   iw out err
    vecs[0]  = mk(1, A0,  0, '0,  1, 0,  1, 0, 1, A0,  0, 8'd1, 0); // single read
    vecs[1]  = mk(0, '0,  1, B0,  1, 1,  0, 1, 1, B0,  1, 8'd1, 0); // grant+rsp at 1
    vecs[2]  = mk(1, A1,  1, B1,  1, 0,  1, 0, 1, A1,  0, 8'd2, 0); // tie -> R
    vecs[3]  = mk(1, A2,  1, B2,  1, 0,  0, 1, 1, B2,  1, 8'd3, 0); // tie -> W
    vecs[4]  = mk(1, A2,  1, B3,  1, 0,  1, 0, 1, A2,  0, 8'd4, 0);
    vecs[5]  = mk(1, A3,  1, B3,  1, 0,  0, 1, 1, B3,  1, 8'd5, 0);
    vecs[6]  = mk(1, A3,  1, B1,  1, 0,  1, 0, 1, A3,  0, 8'd6, 0);
    vecs[7]  = mk(1, A1,  1, B1,  1, 0,  0, 1, 1, B1,  1, 8'd7, 0);
    vecs[8]  = mk(0, '0,  0, '0,  1, 0,  0, 0, 0, B1,  1, 8'd7, 0); // drain
    vecs[9]  = mk(0, '0,  0, '0,  1, 1,  0, 0, 0, B1,  1, 8'd6, 0); // rsp only
    vecs[10] = mk(1, A10, 0, '0,  1, 0,  1, 0, 1, A10, 0, 8'd7, 0);
    vecs[11] = mk(1, A11, 0, '0,  0, 0,  0, 0, 1, A10, 0, 8'd7, 0); // backpressure
    vecs[12] = mk(1, A11, 1, B11, 0, 0,  0, 0, 1, A10, 0, 8'd7, 0);
    vecs[13] = mk(1, A11, 1, B11, 0, 0,  0, 0, 1, A10, 0, 8'd7, 0);
    vecs[14] = mk(1, A11, 1, B11, 1, 0,  0, 1, 1, B11, 1, 8'd8, 0); // load on release
    vecs[15] = mk(1, A12, 1, B12, 1, 0,  0, 0, 0, B11, 1, 8'd8, 0); // no credit
    vecs[16] = mk(1, A12, 1, B12, 1, 1,  0, 0, 0, B11, 1, 8'd7, 0); // rsp at MAX
    vecs[17] = mk(1, A12, 1, B12, 1, 0,  1, 0, 1, A12, 0, 8'd8, 0); // resumes

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    rv = 1'b1; wv = 1'b1; rd = A0; wd = B0; otr = 1'b1; rsp = 1'b0;
    rv2 = 1'b1; wv2 = 1'b0; rd2 = '0; wd2 = '0; otr2 = 1'b1; rsp2 = 1'b0;
    repeat (2) tick();
    chk("rst rready",  rr, 0);
    chk("rst wready",  wr, 0);
    chk("rst tvalid",  otv, 0);
    chk("rst tdata",   otd, 0);
    chk("rst is_write", oiw, 0);
    chk("rst outs",    outs, 0);
    chk("rst err",     err, 0);
    chk("rst rready2", rr2, 0);
    rv = 1'b0; wv = 1'b0; rv2 = 1'b0;
    rst_n = 1'b1;
    tick();

    // ---------------- MAX=2 credit exhaustion ----------------
    accepts = 0;
    rv2 = 1'b1; rd2 = A1;
    for (int c = 0; c < 4; c++) begin
      #3;
      if (rr2) accepts++;
      tick();
    end
    chk("m2 accepts", accepts, 2);
    chk("m2 outs full", outs2, 2);
    #3 chk("m2 rready at max", rr2, 0);
    rsp2 = 1'b1;
    tick();
    rsp2 = 1'b0;
    chk("m2 outs after rsp", outs2, 1);
    #3 chk("m2 rready resumes", rr2, 1);
    tick();
    chk("m2 outs refill", outs2, 2);
    #3 chk("m2 rready full again", rr2, 0);
    rv2 = 1'b0;
    tick();

    // ---------------- table-driven vectors on MAX=8 ----------------
    for (int i = 0; i < 18; i++) begin
      rv = vecs[i].rv; rd = vecs[i].rd; wv = vecs[i].wv; wd = vecs[i].wd;
      otr = vecs[i].otr; rsp = vecs[i].rsp;
      #3;
      chk($sformatf("v%0d rready", i), rr, vecs[i].e_rr);
      chk($sformatf("v%0d wready", i), wr, vecs[i].e_wr);
      tick();
      chk($sformatf("v%0d tvalid", i), otv, vecs[i].e_tv);
      chk($sformatf("v%0d tdata", i), otd, vecs[i].e_td);
      chk($sformatf("v%0d is_write", i), oiw, vecs[i].e_iw);
      chk($sformatf("v%0d outs", i), outs, vecs[i].e_out);
      chk($sformatf("v%0d err", i), err, vecs[i].e_err);
    end

    // ---------------- drain credits, then underflow ----------------
    rv = 1'b0; wv = 1'b0; otr = 1'b1; rsp = 1'b1;
    repeat (8) tick();
    chk("drain outs", outs, 0);
    chk("drain err", err, 0);
    chk("drain tvalid", otv, 0);
    tick();                                  // rsp_done with count 0
    rsp = 1'b0;
    chk("underflow outs", outs, 0);
    chk("underflow err", err, 1);
    rsp = 1'b1; rv = 1'b1; rd = A2;          // rsp at 0 with an accept
    tick();
    rsp = 1'b0; rv = 1'b0;
    chk("uf+inc outs", outs, 1);
    chk("uf+inc tdata", otd, A2);
    tick();
    chk("err sticky", err, 1);
    chk("outs hold", outs, 1);

    // ---------------- async reset mid-transfer ----------------
    rv = 1'b1; rd = A3;
    repeat (2) tick();
    rv = 1'b0;
    otr = 1'b0;
    chk("pre-rst outs", outs, 3);
    chk("pre-rst tvalid", otv, 1);
    #2 rst_n = 1'b0;                         // mid-cycle, away from any edge
    #1;
    chk("async rst tvalid", otv, 0);
    chk("async rst outs", outs, 0);
    chk("async rst err", err, 0);
    rv = 1'b1; wv = 1'b1; otr = 1'b1; rd = A1; wd = B1;
    #1 chk("in-rst rready", rr, 0);
    chk("in-rst wready", wr, 0);
    tick();
    rst_n = 1'b1;
    #3;
    chk("post-rst tie rready", rr, 1);
    chk("post-rst tie wready", wr, 0);
    tick();
    chk("post-rst tdata", otd, A1);
    chk("post-rst is_write", oiw, 0);
    rv = 1'b0; wv = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
